frame_pixel_streamer: RTL and testbench

- Upstream feeder for the FPGA-to-Nano UART pixel sender.
- Reads one frame of IMAGE_SIZE 12-bit pixels from a synchronous-read frame-buffer BRAM port, one pixel at a time.
- Precedes each frame with a sync marker word.
- Presents words on a valid/ready handshake that connects directly to the sender's valid_in/ready_out pair.

---
 rtl/frame_pixel_streamer.sv | 132 +++++++++++++
 tb/tb_frame_pixel_streamer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: reads one frame of pixels from a synchronous-read
// frame buffer and offers it downstream on a valid/ready handshake, preceded
// by a sync marker word. Pixel values equal to the marker are escaped to
// marker-1 so the receiver can always find the frame start.
module frame_pixel_streamer #(
    parameter int                 IMAGE_SIZE = 100,
    parameter int                 ADDR_W     = 17,
    parameter int                 PIXEL_W    = 12,
    parameter logic [PIXEL_W-1:0] SYNC_WORD  = 12'hFFF,
    parameter bit                 CONTINUOUS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [PIXEL_W-1:0] ram_rdata,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               sof,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        LOAD,
        PRESENT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMAGE_SIZE - 1);

    state_t            state;
    logic [ADDR_W-1:0] index;

    // A pixel that happens to equal the marker is nudged down by one so the
    // marker value is reserved for frame starts only.
    function automatic logic [PIXEL_W-1:0] escape_marker(input logic [PIXEL_W-1:0] word);
        return (word == SYNC_WORD) ? (SYNC_WORD - PIXEL_W'(1)) : word;
    endfunction

    // Frame sequencer: marker, then fetch/load/present per pixel; all outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            index      <= '0;
            ram_addr   <= '0;
            pixel_out  <= '0;
            valid_out  <= 1'b0;
            sof        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= HEADER;
                        pixel_out <= SYNC_WORD;
                        sof       <= 1'b1;
                        valid_out <= 1'b1;
                        ram_addr  <= '0;
                        index     <= '0;
                        busy      <= 1'b1;
                    end
                end

                HEADER: begin
                    // Marker is held until the sender takes it.
                    if (ready_in) begin
                        state     <= FETCH;
                        valid_out <= 1'b0;
                        sof       <= 1'b0;
                    end
                end

                FETCH: begin
                    // ram_addr is already stable; this cycle covers the BRAM read latency.
                    state <= LOAD;
                end

                LOAD: begin
                    pixel_out <= escape_marker(ram_rdata);
                    valid_out <= 1'b1;
                    state     <= PRESENT;
                end

                PRESENT: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        if (index == LAST_IDX) begin
                            frame_done <= 1'b1;
                            index      <= '0;
                            ram_addr   <= '0;
                            state      <= DONE;
                        end else begin
                            index    <= index + ADDR_W'(1);
                            ram_addr <= index + ADDR_W'(1);
                            state    <= FETCH;
                        end
                    end
                end

                DONE: begin
                    if (CONTINUOUS) begin
                        // Free-running mode: next frame's marker goes out immediately.
                        state     <= HEADER;
                        pixel_out <= SYNC_WORD;
                        sof       <= 1'b1;
                        valid_out <= 1'b1;
                        ram_addr  <= '0;
                        index     <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    valid_out <= 1'b0;
                    sof       <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer. Two instances: A (4 pixels, single-shot)
// and B (3 pixels, continuous). A per-cycle word-stream model predicts what
// each instance must offer; directed phases pin the model with literals.
module tb_frame_pixel_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a = 1'b0, start_a = 1'b0, ready_a = 1'b0;
    logic [16:0] addr_a;
    logic [11:0] rdata_a = '0, pixel_a;
    logic        valid_a, sof_a, busy_a, fd_a;

    logic        reset_b = 1'b0, start_b = 1'b0, ready_b = 1'b0;
    logic [16:0] addr_b;
    logic [11:0] rdata_b = '0, pixel_b;
    logic        valid_b, sof_b, busy_b, fd_b;

    logic [11:0] mem_a [4];
    logic [11:0] mem_b [3];

    frame_pixel_streamer #(
        .IMAGE_SIZE(4), .ADDR_W(17), .PIXEL_W(12), .SYNC_WORD(12'hFFF), .CONTINUOUS(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .ram_addr(addr_a), .ram_rdata(rdata_a),
        .pixel_out(pixel_a), .valid_out(valid_a), .ready_in(ready_a), .sof(sof_a),
        .busy(busy_a), .frame_done(fd_a)
    );

    frame_pixel_streamer #(
        .IMAGE_SIZE(3), .ADDR_W(17), .PIXEL_W(12), .SYNC_WORD(12'hFFF), .CONTINUOUS(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .ram_addr(addr_b), .ram_rdata(rdata_b),
        .pixel_out(pixel_b), .valid_out(valid_b), .ready_in(ready_b), .sof(sof_b),
        .busy(busy_b), .frame_done(fd_b)
    );

    // Synchronous-read frame buffers; out-of-range addresses read as zero.
    always @(posedge clk) begin
        rdata_a <= (addr_a < 17'd4) ? mem_a[addr_a[1:0]] : 12'h000;
        rdata_b <= (addr_b < 17'd3) ? mem_b[addr_b[1:0]] : 12'h000;
    end

    int ncmp  = 0;
    int nfail = 0;

    // Model state per instance: cycles until the next word is offered
    // (-1 = nothing pending), position within the frame, expected pulses.
    int          wait_c [2];
    int          pos_c  [2];
    int          frames [2];
    bit          fd_e   [2];
    bit          busy_e [2];
    bit          armed  [2];
    logic [11:0] log_a [$];
    logic [11:0] log_b [$];

    task automatic chk(input string nm, input int act, input int req);
        ncmp++;
        if (act !== req) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int npix(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [11:0] exp_word(input int d, input int p);
        logic [11:0] w;
        if (p == 0) return 12'hFFF;
        if (d == 0) w = mem_a[p-1];
        else        w = mem_b[p-1];
        return (w == 12'hFFF) ? 12'hFFE : w;
    endfunction

    task automatic model_reset(input int d);
        wait_c[d] = -1;
        pos_c[d]  = 0;
        fd_e[d]   = 1'b0;
        busy_e[d] = 1'b0;
    endtask

    task automatic check_cycle(input int d, input logic rst, input logic st, input logic rdy,
                               input logic vld, input logic sf, input logic bsy, input logic fd,
                               input logic [11:0] px);
        string tag;
        bit    expv;
        bit    busy_n;
        bit    fd_n;
        tag = (d == 0) ? "A" : "B";
        if (!armed[d]) begin
            if (!rst) armed[d] = 1'b1;
            model_reset(d);
            return;
        end
        expv = (wait_c[d] == 0);
        chk({tag, "_valid"}, int'(vld), int'(expv));
        chk({tag, "_sof"}, int'(sf), int'(expv && pos_c[d] == 0));
        chk({tag, "_frame_done"}, int'(fd), int'(fd_e[d]));
        chk({tag, "_busy"}, int'(bsy), int'(busy_e[d]));
        if (expv) chk({tag, "_word"}, int'(px), int'(exp_word(d, pos_c[d])));
        if (!rst) begin
            model_reset(d);
            return;
        end
        fd_n   = 1'b0;
        busy_n = busy_e[d];
        if (fd_e[d] && d == 0) busy_n = 1'b0;
        if (!busy_e[d] && st) begin
            wait_c[d] = 0;
            pos_c[d]  = 0;
            busy_n    = 1'b1;
        end else if (wait_c[d] > 0) begin
            wait_c[d]--;
        end else if (wait_c[d] == 0 && rdy) begin
            if (d == 0) log_a.push_back(px);
            else        log_b.push_back(px);
            if (pos_c[d] == npix(d)) begin
                fd_n      = 1'b1;
                pos_c[d]  = 0;
                wait_c[d] = (d == 0) ? -1 : 1;
                frames[d]++;
            end else begin
                pos_c[d]++;
                wait_c[d] = 2;
            end
        end
        fd_e[d]   = fd_n;
        busy_e[d] = busy_n;
    endtask

    // Single compare process: every cycle, both instances against the model.
    always @(negedge clk) begin
        check_cycle(0, reset_a, start_a, ready_a, valid_a, sof_a, busy_a, fd_a, pixel_a);
        check_cycle(1, reset_b, start_b, ready_b, valid_b, sof_b, busy_b, fd_b, pixel_b);
    end

    task automatic wait_done_a(input string nm);
        for (int i = 0; i < 400; i++) begin
            if (fd_a) break;
            tick();
        end
        chk(nm, int'(fd_a), 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Instance B: one start, random backpressure forever.
    initial begin
        mem_b = '{12'h001, 12'hFFF, 12'h7A5};
        repeat (3) tick();
        reset_b = 1'b1;
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        forever begin
            ready_b = ($urandom_range(0, 2) != 0);
            tick();
        end
    end

    // Instance A: directed phases, then randomized traffic.
    initial begin
        int found;
        int held;
        int n456;
        int nw;
        mem_a = '{12'h123, 12'h456, 12'h789, 12'hABC};
        repeat (3) tick();
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_addr", int'(addr_a), 0);
        chk("rst_pixel", int'(pixel_a), 0);
        chk("rst_sof", int'(sof_a), 0);
        chk("rst_frame_done", int'(fd_a), 0);
        reset_a = 1'b1;
        ready_a = 1'b1;
        tick();

        // Basic frame with a 50-cycle stall on 0x456.
        pulse_start_a();
        chk("latency_valid", int'(valid_a), 1);
        chk("hdr_sof", int'(sof_a), 1);
        chk("hdr_word", int'(pixel_a), 12'hFFF);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (valid_a && pixel_a == 12'h456) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("find_456", found, 1);
        ready_a = 1'b0;
        held = 0;
        repeat (50) begin
            tick();
            if (valid_a && pixel_a == 12'h456) held++;
        end
        chk("bp_hold", held, 50);
        ready_a = 1'b1;
        wait_done_a("frame1_done");
        tick();
        chk("frame1_idle", int'(busy_a), 0);
        chk("frame1_words", log_a.size(), 5);
        if (log_a.size() == 5) begin
            chk("frame1_w0", int'(log_a[0]), 12'hFFF);
            chk("frame1_w1", int'(log_a[1]), 12'h123);
            chk("frame1_w2", int'(log_a[2]), 12'h456);
            chk("frame1_w3", int'(log_a[3]), 12'h789);
            chk("frame1_w4", int'(log_a[4]), 12'hABC);
        end
        n456 = 0;
        foreach (log_a[i]) if (log_a[i] == 12'h456) n456++;
        chk("bp_single_xfer", n456, 1);

        // Marker escape, plus a start pulse while busy that must be ignored.
        log_a.delete();
        mem_a = '{12'h321, 12'h0F0, 12'hFFF, 12'h800};
        pulse_start_a();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (valid_a && log_a.size() == 2) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("find_present", found, 1);
        pulse_start_a();
        wait_done_a("frame2_done");
        chk("frame2_words", log_a.size(), 5);
        if (log_a.size() == 5) chk("escape_word", int'(log_a[3]), 12'hFFE);
        repeat (20) tick();
        chk("no_second_frame", log_a.size(), 5);
        chk("frame2_idle", int'(busy_a), 0);

        // Reset while pixel index 2 is presented.
        log_a.delete();
        foreach (mem_a[i]) mem_a[i] = 12'($urandom);
        pulse_start_a();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (valid_a && log_a.size() == 3) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("find_idx2", found, 1);
        ready_a = 1'b0;
        reset_a = 1'b0;
        tick();
        reset_a = 1'b1;
        chk("midrst_valid", int'(valid_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_addr", int'(addr_a), 0);
        ready_a = 1'b1;
        pulse_start_a();
        chk("restart_word", int'(pixel_a), 12'hFFF);
        chk("restart_sof", int'(sof_a), 1);
        wait_done_a("restart_done");
        tick();

        // Randomized traffic: data with frequent markers, backpressure, starts, resets.
        foreach (mem_a[i]) mem_a[i] = ($urandom_range(0, 2) == 0) ? 12'hFFF : 12'($urandom);
        nw = frames[0];
        for (int i = 0; i < 3000; i++) begin
            reset_a = ($urandom_range(0, 299) != 0);
            start_a = ($urandom_range(0, 15) == 0);
            ready_a = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset_a = 1'b1;
        start_a = 1'b0;
        ready_a = 1'b1;
        repeat (5) tick();
        chk("rand_frames_seen", int'(frames[0] - nw >= 3), 1);

        // Continuous instance: literal start of the stream and frame count.
        chk("cont_frames", int'(frames[1] >= 3), 1);
        chk("cont_words", int'(log_b.size() >= 5), 1);
        if (log_b.size() >= 5) begin
            chk("cont_w0", int'(log_b[0]), 12'hFFF);
            chk("cont_w1", int'(log_b[1]), 12'h001);
            chk("cont_w2", int'(log_b[2]), 12'hFFE);
            chk("cont_w3", int'(log_b[3]), 12'h7A5);
            chk("cont_w4", int'(log_b[4]), 12'hFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
